button_start_ctrl: RTL and testbench
====================================

BUTTON_START_CTRL -- requirements
Module: button_start_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1: consecutive stable cycles needed to accept a new button level (board builds override).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 8: cycles allowed after a start pulse for busy to rise.
REQ-003 SHALL use one clock and an asynchronous, active-high reset; all other inputs are synchronous to the clock unless stated.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-high reset.
REQ-006 SHALL have port button1  input  1  raw active-low push button 1, asynchronous.
REQ-007 SHALL have port button2  input  1  raw active-low push button 2, asynchronous.
REQ-008 SHALL have port busy  input  1  downstream top busy flag.
REQ-009 SHALL have port start1  output  1  one-cycle start pulse for transaction 1.
REQ-010 SHALL have port start2  output  1  one-cycle start pulse for transaction 2.
REQ-011 SHALL have port pending  output  2  queued requests; bit0 = button1, bit1 = button2.
REQ-012 SHALL have port ack_err  output  1  sticky flag: busy never rose within ACK_TIMEOUT.

Function
REQ-013 SHALL pass each button through a 2-flop synchronizer.
REQ-014 SHALL debounce each button: the debounced level takes the synchronized level once that level has differed from it for DEBOUNCE_CYCLES consecutive cycles; any reversion clears the count.
REQ-015 SHALL record a press only on a debounced 1->0 transition; holding a button low yields exactly one press, and a release yields none.
REQ-016 SHALL set the button's pending bit on a press; a press on an already-pending button is dropped.
REQ-017 SHALL clear a pending bit in the cycle its start pulse is issued; a new press in that same cycle wins and leaves the bit set.
REQ-018 SHALL run FSM states IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
REQ-019 SHALL move IDLE->ISSUE when pending!=0 and busy=0; otherwise it stays in IDLE.
REQ-020 SHALL, in ISSUE, assert exactly one registered start pulse for one cycle, then go to WAIT_ACK.
REQ-021 SHALL, in WAIT_ACK, go to WAIT_DONE when busy=1; after ACK_TIMEOUT cycles without busy it SHALL set ack_err and go to IDLE.
REQ-022 SHALL, in WAIT_DONE, go to IDLE when busy=0.
REQ-023 SHALL grant round-robin when both bits are pending: the button not granted last goes first; the first grant after reset goes to button1.
REQ-024 SHALL never assert start1 and start2 in the same cycle.
REQ-025 SHALL have a latency, with DEBOUNCE_CYCLES=1 and the block idle, where start rises at rising edge N+3 (N = first edge sampling button low); each extra debounce cycle adds one edge.
REQ-026 SHALL size the debounce and timeout counters to $clog2(param+1) bits, with no wrap-around: counters saturate at their terminal value.

Reset
REQ-027 SHALL, on reset assertion, immediately force start1=0, start2=0, pending=0, ack_err=0, FSM=IDLE, counters=0, and last grant=button2.
REQ-028 SHALL preset synchronizer and debounced levels to 1 (released) on reset, so that a button held through reset release generates no press.
REQ-029 SHALL drop all queued requests on reset mid-transaction, with no start pulse after reset deasserts.

Structure
REQ-030 SHALL place the FSM state enum and default DEBOUNCE_CYCLES/ACK_TIMEOUT constants in shared package button_start_pkg.
REQ-031 SHALL implement synchronizer+debounce+press-detect as sub-module button_debounce, instantiated twice.

Verification
REQ-032 SHALL cover: button1 low for 1 cycle at edge 1, busy=0 -> start1 high during exactly one cycle from edge 4; start2 stays 0.
REQ-033 SHALL cover: with DEBOUNCE_CYCLES=4, a button2 3-cycle low glitch -> no pending, no start2; a 6-cycle low press -> exactly one start2.
REQ-034 SHALL cover: button1 and button2 pressed in the same cycle, busy raised 1 cycle after each start and held 10 cycles -> start1 first, then start2 after busy falls; pending goes 11->10->00.
REQ-035 SHALL cover: a button1 press with busy tied 0, ACK_TIMEOUT=8 -> one start1, ack_err=1 eight cycles later, FSM back in IDLE, ack_err held until reset.
REQ-036 SHALL cover: button2 pressed while busy=1 in WAIT_DONE -> pending[1]=1 and no start2 until the cycle after busy falls, then start2.
REQ-037 SHALL cover: reset asserted mid-WAIT_DONE with pending=01 -> all outputs 0 immediately; button held low through reset produces no start.

Source files
------------

// File: rtl/button_start_pkg.sv
// Shared types and default parameter values for the button-driven start controller.
package button_start_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 1;
    localparam int ACK_TIMEOUT_DEF     = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef enum logic {
        GRANT_B1 = 1'b0,
        GRANT_B2 = 1'b1
    } grant_t;

endpackage

// File: rtl/button_debounce.sv
// One raw active-low button: 2-flop synchronizer, saturating debounce counter and
// a single-cycle press strobe on each accepted 1->0 transition.
module button_debounce
    import button_start_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          armed;
    logic [1:0]    vld;
    logic [CW-1:0] cnt;
    logic          accept;

    assign accept = (sync2 != level) && (cnt == CNT_TC);
    assign press  = accept && level && armed;

    // armed only once a genuinely sampled release has been seen, so a button
    // held through reset cannot masquerade as a fresh press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b1;
            cnt   <= '0;
            vld   <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            vld   <= {vld[0], 1'b1};
            if (vld[1] && sync2)
                armed <= 1'b1;
            if (sync2 == level)
                cnt <= '0;
            else if (accept) begin
                level <= sync2;
                cnt   <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/button_start_ctrl.sv
// Turns two push buttons into queued, round-robin start pulses and watches the
// downstream busy handshake for a missing acknowledge.
//
// state     | meaning
// IDLE      | waiting for a pending request while busy is low
// ISSUE     | start pulse high for the granted button
// WAIT_ACK  | waiting for busy to rise, timeout sets ack_err
// WAIT_DONE | downstream busy, waiting for it to fall
module button_start_ctrl
    import button_start_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int ACK_TIMEOUT     = ACK_TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button1,
    input  logic       button2,
    input  logic       busy,
    output logic       start1,
    output logic       start2,
    output logic [1:0] pending,
    output logic       ack_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_TC = TW'(ACK_TIMEOUT - 1);

    state_t        state, state_n;
    grant_t        last, last_n, sel;
    logic [1:0]    press, clr, pending_n;
    logic          start1_n, start2_n, ack_err_n;
    logic [TW-1:0] tcnt, tcnt_n;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
        .clk(clk), .reset(reset), .button(button1), .press(press[0])
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
        .clk(clk), .reset(reset), .button(button2), .press(press[1])
    );

    always_comb begin
        state_n   = state;
        last_n    = last;
        start1_n  = 1'b0;
        start2_n  = 1'b0;
        ack_err_n = ack_err;
        tcnt_n    = '0;
        clr       = 2'b00;

        if (pending == 2'b11)
            sel = (last == GRANT_B1) ? GRANT_B2 : GRANT_B1;
        else if (pending[1])
            sel = GRANT_B2;
        else
            sel = GRANT_B1;

        case (state)
            IDLE: begin
                if ((pending != 2'b00) && !busy) begin
                    state_n = ISSUE;
                    last_n  = sel;
                    if (sel == GRANT_B1) begin
                        start1_n = 1'b1;
                        clr      = 2'b01;
                    end else begin
                        start2_n = 1'b1;
                        clr      = 2'b10;
                    end
                end
            end
            ISSUE:
                state_n = WAIT_ACK;
            WAIT_ACK: begin
                if (busy)
                    state_n = WAIT_DONE;
                else if (tcnt == TO_TC) begin
                    ack_err_n = 1'b1;
                    state_n   = IDLE;
                end else
                    tcnt_n = tcnt + 1'b1;
            end
            WAIT_DONE: begin
                if (!busy)
                    state_n = IDLE;
            end
            default:
                state_n = IDLE;
        endcase

        // a press landing in the grant cycle re-arms the bit it would have cleared
        pending_n = (pending & ~clr) | press;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            last    <= GRANT_B2;
            start1  <= 1'b0;
            start2  <= 1'b0;
            pending <= 2'b00;
            ack_err <= 1'b0;
            tcnt    <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            start1  <= start1_n;
            start2  <= start2_n;
            pending <= pending_n;
            ack_err <= ack_err_n;
            tcnt    <= tcnt_n;
        end
    end

endmodule

// File: tb/tb_button_start_ctrl.sv
// Self-checking bench: expected start pulses (which button, which edge) are queued
// as stimulus is driven and matched by a monitor when the DUT pulses.
module tb_button_start_ctrl;

    typedef struct {
        int id;
        int at_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic b1a = 1'b1, b2a = 1'b1, busya = 1'b0;
    logic s1a, s2a, ea;
    logic [1:0] pa;

    logic b1b = 1'b1, b2b = 1'b1, busyb = 1'b0;
    logic s1b, s2b, eb;
    logic [1:0] pb;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    exp_t qa[$];
    exp_t qb[$];
    int d, c, f, g, j, k, h;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_start_ctrl #(.DEBOUNCE_CYCLES(1), .ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .reset(reset), .button1(b1a), .button2(b2a), .busy(busya),
        .start1(s1a), .start2(s2a), .pending(pa), .ack_err(ea)
    );

    button_start_ctrl #(.DEBOUNCE_CYCLES(4), .ACK_TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .button1(b1b), .button2(b2b), .busy(busyb),
        .start1(s1b), .start2(s2b), .pending(pb), .ack_err(eb)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic at(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic push_a(input int id, input int e);
        exp_t x;
        x.id = id;
        x.at_edge = e;
        qa.push_back(x);
    endtask

    task automatic push_b(input int id, input int e);
        exp_t x;
        x.id = id;
        x.at_edge = e;
        qb.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (s1a || s2a) begin
            check_val("excl_a", 32'(s1a & s2a), 32'd0);
            if (qa.size() == 0)
                check_val("unexpected_start_a", 32'(qa.size()), 32'd1);
            else begin
                e = qa.pop_front();
                check_val("start_id_a", s1a ? 32'd1 : 32'd2, 32'(e.id));
                check_val("start_edge_a", 32'(cyc), 32'(e.at_edge));
            end
        end
        if (s1b || s2b) begin
            check_val("excl_b", 32'(s1b & s2b), 32'd0);
            if (qb.size() == 0)
                check_val("unexpected_start_b", 32'(qb.size()), 32'd1);
            else begin
                e = qb.pop_front();
                check_val("start_id_b", s1b ? 32'd1 : 32'd2, 32'(e.id));
                check_val("start_edge_b", 32'(cyc), 32'(e.at_edge));
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        check_val("rst_pend_a", 32'(pa), 32'd0);
        check_val("rst_start_a", 32'({s1a, s2a}), 32'd0);
        check_val("rst_err_a", 32'(ea), 32'd0);
        check_val("rst_pend_b", 32'(pb), 32'd0);
        reset = 1'b0;

        // both buttons together, busy handshake 1 cycle after each start, 10 cycles long
        d = cyc + 6;
        at(d);     b1a = 1'b0; b2a = 1'b0; push_a(1, d + 4);
        at(d + 1); b1a = 1'b1; b2a = 1'b1;
        at(d + 3); check_val("pend_both", 32'(pa), 32'd3);
        at(d + 4); check_val("pend_after_s1", 32'(pa), 32'd2); busya = 1'b1; push_a(2, d + 16);
        at(d + 14); busya = 1'b0;
        at(d + 16); check_val("pend_after_s2", 32'(pa), 32'd0); busya = 1'b1;
        at(d + 26); busya = 1'b0; check_val("no_err_handshake", 32'(ea), 32'd0);

        // single 1-cycle press, busy tied low: latency and acknowledge timeout
        c = d + 30;
        at(c);      b1a = 1'b0; push_a(1, c + 4);
        at(c + 1);  b1a = 1'b1;
        at(c + 3);  check_val("pend_b1", 32'(pa), 32'd1);
        at(c + 4);  check_val("pend_b1_clr", 32'(pa), 32'd0);
        at(c + 12); check_val("err_before_to", 32'(ea), 32'd0);
        at(c + 13); check_val("err_at_to", 32'(ea), 32'd1);

        // round robin: button1 granted last, so button2 goes first
        f = c + 16;
        at(f);      b1a = 1'b0; b2a = 1'b0; push_a(2, f + 4); push_a(1, f + 14);
        at(f + 1);  b1a = 1'b1; b2a = 1'b1;
        at(f + 4);  check_val("rr_pend", 32'(pa), 32'd1);
        at(f + 14); check_val("rr_pend_clr", 32'(pa), 32'd0);
        at(f + 20); check_val("err_sticky", 32'(ea), 32'd1);

        // button2 pressed during WAIT_DONE waits for busy to fall
        g = f + 26;
        at(g);      b1a = 1'b0; push_a(1, g + 4);
        at(g + 1);  b1a = 1'b1;
        at(g + 4);  busya = 1'b1;
        at(g + 8);  b2a = 1'b0;
        at(g + 9);  b2a = 1'b1;
        at(g + 12); check_val("pend_wait_done", 32'(pa), 32'd2);
        at(g + 15); busya = 1'b0; push_a(2, g + 17);
        at(g + 16); check_val("pend_held", 32'(pa), 32'd2);
        at(g + 17); check_val("pend_served", 32'(pa), 32'd0);

        // DEBOUNCE_CYCLES=4: 3-cycle glitch rejected, 6-cycle press accepted once
        j = g + 30;
        at(j);      b2b = 1'b0;
        at(j + 3);  b2b = 1'b1;
        at(j + 8);  check_val("glitch_pend_b", 32'(pb), 32'd0);
        k = j + 12;
        at(k);      b2b = 1'b0; push_b(2, k + 7);
        at(k + 6);  b2b = 1'b1; check_val("press_pend_b", 32'(pb), 32'd2);
        at(k + 7);  check_val("press_pend_b_clr", 32'(pb), 32'd0);

        // reset mid-WAIT_DONE with pending=01, button1 held low through reset
        h = k + 20;
        at(h);      b1a = 1'b0; push_a(1, h + 4);
        at(h + 1);  b1a = 1'b1;
        at(h + 4);  busya = 1'b1;
        at(h + 6);  b1a = 1'b0;
        at(h + 10); check_val("pend_pre_rst", 32'(pa), 32'd1);
        reset = 1'b1;
        busya = 1'b0;
        #1;
        check_val("rst_now_pend", 32'(pa), 32'd0);
        check_val("rst_now_start", 32'({s1a, s2a}), 32'd0);
        check_val("rst_now_err", 32'(ea), 32'd0);
        at(h + 12); reset = 1'b0;
        at(h + 30); check_val("held_no_pend", 32'(pa), 32'd0);
        check_val("held_no_err", 32'(ea), 32'd0);
        b1a = 1'b1;
        at(h + 36); b1a = 1'b0; push_a(1, h + 40);
        at(h + 37); b1a = 1'b1;
        at(h + 52);
        check_val("missing_starts_a", 32'(qa.size()), 32'd0);
        check_val("missing_starts_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
